// File: rtl/imem_responder.sv
// Instruction memory responder: serves a 16-bit word LATENCY cycles after a fetch request,
// holding stall to fetch meanwhile. Optional misaligned-fetch error via IMEM_ALIGN_ERR_EN.
module imem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        stall,
  output logic        done,
  output logic [15:0] instr,
  output logic        err,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  // Countdown preload: BUSY lasts LATENCY-1 cycles, DONE entered when count reaches zero
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_mis;
  logic              accept;
  logic              unused_bits;
  logic [15:0]       mem [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (LATENCY == 1) ? DONE : BUSY;
      BUSY: if (cnt == 4'd0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs; a single-cycle accept reads the live address
  always_comb begin
    accept = (state == IDLE) && req;
    stall  = accept || (state == BUSY);
    rd_idx = (state == IDLE) ? addr[ADDR_W:1] : lat_idx;
  end

`ifdef IMEM_ALIGN_ERR_EN
  logic lat_mis;

  assign rd_mis = (state == IDLE) ? addr[0] : lat_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_mis <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (accept) lat_mis <= addr[0];
      err <= (state_nxt == DONE) && rd_mis;
    end
  end
`else
  assign rd_mis = 1'b0;
  assign err    = 1'b0;
`endif

  // Transaction datapath; instr reads before any same-edge write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      lat_idx <= '0;
      done    <= 1'b0;
      instr   <= 16'h0000;
    end else begin
      if (accept) begin
        lat_idx <= addr[ADDR_W:1];
        cnt     <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      done <= (state_nxt == DONE);
      if (state_nxt == DONE) instr <= rd_mis ? 16'h0000 : mem[rd_idx];
    end
  end

  // Preload port; array is never cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[ADDR_W:1]] <= wr_data;
  end

  assign unused_bits = ^{addr, wr_addr};

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against a timestamp-based transaction model,
// plus directed literal checks pinning latency, write ordering, reset abort and alignment.
module tb_imem_responder;

  localparam int LAT = 3;
`ifdef IMEM_ALIGN_ERR_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, wr_en;
  logic [15:0] addr, wr_addr, wr_data;
  logic        stall, done, err;
  logic [15:0] instr;

  imem_responder dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .stall(stall), .done(done), .instr(instr), .err(err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: absolute cycle of the pending done pulse (-1 = none), plus word array
  logic [15:0] mem_m [256];
  int          cyc = 0;
  int          done_at = -1;
  logic [7:0]  lat_idx_m = '0;
  logic        lat_mis_m = 1'b0;
  logic [15:0] instr_m = '0;
  bit          model_on = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: drive at negedge, compare against model, then advance model over the edge
  task automatic step(input logic r, input logic rq, input logic [15:0] a,
                      input logic we, input logic [15:0] wa, input logic [15:0] wd);
    logic done_e, stall_e, err_e;
    @(negedge clk);
    rst = r; req = rq; addr = a; wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    if (model_on) begin
      done_e  = (done_at == cyc);
      stall_e = (done_at > cyc) || ((done_at < 0) && rq);
      err_e   = done_e && lat_mis_m && ALIGN;
      chk("m_done", 16'(done), 16'(done_e));
      chk("m_stall", 16'(stall), 16'(stall_e));
      chk("m_err", 16'(err), 16'(err_e));
      chk("m_instr", instr, instr_m);
    end
    if (r) begin
      done_at = -1;
      instr_m = 16'h0000;
    end else if (done_at == cyc) begin
      done_at = -1;
    end else if ((done_at < 0) && rq) begin
      done_at   = cyc + LAT;
      lat_idx_m = a[8:1];
      lat_mis_m = a[0];
    end
    if (!r && (done_at == cyc + 1))
      instr_m = (ALIGN && lat_mis_m) ? 16'h0000 : mem_m[lat_idx_m];
    if (we) mem_m[wa[8:1]] = wd;
    if (r) model_on = 1'b1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b0, 1'b1, a, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] wa, input logic [15:0] wd);
    step(1'b0, 1'b0, 16'h0, 1'b1, wa, wd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 16'h0;
    rst = 1'b1; req = 1'b0; addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset held two cycles, then reset values and stall with/without req
    step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_instr", instr, 16'h0);
    chk("rst_stall_req", 16'(stall), 16'h1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    chk("rst_stall_noreq", 16'(stall), 16'h0);

    // Preload whole array, then fixed words
    for (int i = 0; i < 256; i++) wr(16'(i * 2), 16'($urandom));
    wr(16'h0004, 16'hA5C3);
    wr(16'h0000, 16'h1234);
    wr(16'h0002, 16'h5678);

    // Basic read latency
    rd(16'h0004);            chk("t2_stall_t", 16'(stall), 16'h1);
    idle();                  chk("t2_stall_t1", 16'(stall), 16'h1);
    idle();                  chk("t2_stall_t2", 16'(stall), 16'h1);
    idle();                  chk("t2_done", 16'(done), 16'h1);
                             chk("t2_instr", instr, 16'hA5C3);
                             chk("t2_stall_done", 16'(stall), 16'h0);
    idle();                  chk("t2_done_off", 16'(done), 16'h0);

    // Back-to-back with req held high
    rd(16'h0000); rd(16'h0000); rd(16'h0000);
    rd(16'h0000);            chk("t3_done1", 16'(done), 16'h1);
                             chk("t3_instr1", instr, 16'h1234);
                             chk("t3_stall_done", 16'(stall), 16'h0);
    rd(16'h0002);            chk("t3_accept2", 16'(stall), 16'h1);
    rd(16'h0002); rd(16'h0002);
    rd(16'h0002);            chk("t3_done2", 16'(done), 16'h1);
                             chk("t3_instr2", instr, 16'h5678);
    idle();

    // Write during BUSY before DONE-entry edge, then on the same edge
    rd(16'h0004);
    wr(16'h0004, 16'h1111);
    idle();
    idle();                  chk("t4_early_wr", instr, 16'h1111);
    wr(16'h0004, 16'hA5C3);
    rd(16'h0004);
    idle();
    wr(16'h0004, 16'h2222);
    idle();                  chk("t4_same_edge", instr, 16'hA5C3);
    wr(16'h0004, 16'hA5C3);

    // Reset mid-transaction aborts; array survives
    rd(16'h0004);
    step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    idle();                  chk("t5_stall_low", 16'(stall), 16'h0);
    idle();                  chk("t5_no_done", 16'(done), 16'h0);
    idle();                  chk("t5_no_done2", 16'(done), 16'h0);
    rd(16'h0004); idle(); idle();
    idle();                  chk("t5_reread", instr, 16'hA5C3);

    // Misaligned fetch
    rd(16'h0005); idle(); idle();
    idle();                  chk("t6_done", 16'(done), 16'h1);
                             chk("t6_err", 16'(err), 16'(ALIGN));
                             chk("t6_instr", instr, ALIGN ? 16'h0000 : 16'hA5C3);
    idle();                  chk("t6_err_off", 16'(err), 16'h0);

    // Random traffic; writes focus on a few words to collide with reads
    for (int i = 0; i < 3000; i++) begin
      logic        r, rq, we;
      logic [15:0] a, wa;
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 2) != 0);
      a  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      we = ($urandom_range(0, 2) == 0);
      wa = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      step(r, rq, a, we, wa, 16'($urandom));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
